regfile_sb: RTL and testbench

Parametrised register file with per-register pending-write scoreboard for the pipelined MIPS datapath. Provides two asynchronous read ports, one synchronous write port, a debug read port, and per-register outstanding-write counters. The counters flag read-after-write hazards to the decode stage. The block sits in ID, with writeback driving the write port from WB and the issue port driven from ID when an instruction with a destination register leaves decode.

---
 rtl/regfile_sb_if.sv | 36 +++
 rtl/regfile_sb.sv | 141 ++++++++++++++
 tb/tb_regfile_sb.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - read, write, issue and debug signal bundle for regfile_sb
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // operand read ports
  logic [ADDR_W-1:0] rr1;
  logic [ADDR_W-1:0] rr2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              re1;
  logic              re2;
  // writeback port
  logic              we;
  logic [ADDR_W-1:0] wr;
  logic [DATA_W-1:0] wd;
  // issue port from decode
  logic              iss;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_rdy;
  logic              hazard;
  // debug read port and error flag
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              sb_err;

  modport master (
    output rr1, rr2, re1, re2, we, wr, wd, iss, iss_rd, dbg_addr,
    input  rd1, rd2, iss_rdy, hazard, dbg_data, sb_err
  );

  modport slave (
    input  rr1, rr2, re1, re2, we, wr, wd, iss, iss_rd, dbg_addr,
    output rd1, rd2, iss_rdy, hazard, dbg_data, sb_err
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with pending-write scoreboard (scoreboard enabled by REGFILE_SB_EN)
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // register 0 is hardwired to zero when ZERO_REG is set
  logic wr_is_zero;
  logic wr_ok;
  assign wr_is_zero = (ZERO_REG != 0) && (bus.wr == '0);
  assign wr_ok      = bus.we && !wr_is_zero;

  // stored contents seen by each read port, with register 0 masked
  logic [DATA_W-1:0] stored1;
  logic [DATA_W-1:0] stored2;
  assign stored1 = ((ZERO_REG != 0) && (bus.rr1 == '0)) ? '0 : regs[bus.rr1];
  assign stored2 = ((ZERO_REG != 0) && (bus.rr2 == '0)) ? '0 : regs[bus.rr2];

  // debug port never forwards: it always shows committed state
  assign bus.dbg_data = ((ZERO_REG != 0) && (bus.dbg_addr == '0)) ? '0 : regs[bus.dbg_addr];

  // register storage: cleared by reset, written from writeback
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.wr] <= bus.wd;
    end
  end

`ifdef REGFILE_SB_EN

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt     [DEPTH];
  logic [CNT_W-1:0] cnt_nxt [DEPTH];
  logic             sb_err_q;

  logic iss_is_zero;
  logic iss_acc;
  logic underflow;
  logic fwd1;
  logic fwd2;
  logic pend1;
  logic pend2;

  // a full counter refuses further issues to that destination
  assign bus.iss_rdy = (cnt[bus.iss_rd] != CNT_MAX);

  assign iss_is_zero = (ZERO_REG != 0) && (bus.iss_rd == '0);
  assign iss_acc     = bus.iss && bus.iss_rdy && !iss_is_zero;

  // a writeback with nothing outstanding is a bookkeeping error upstream
  assign underflow = wr_ok && (cnt[bus.wr] == '0);

  // same-cycle writeback forwarding onto the operand ports
  assign fwd1 = wr_ok && (bus.wr == bus.rr1);
  assign fwd2 = wr_ok && (bus.wr == bus.rr2);
  assign bus.rd1 = fwd1 ? bus.wd : stored1;
  assign bus.rd2 = fwd2 ? bus.wd : stored2;

  // last outstanding write landing this cycle is covered by forwarding
  assign pend1 = (cnt[bus.rr1] != '0) &&
                 !((cnt[bus.rr1] == CNT_ONE) && bus.we && (bus.wr == bus.rr1));
  assign pend2 = (cnt[bus.rr2] != '0) &&
                 !((cnt[bus.rr2] == CNT_ONE) && bus.we && (bus.wr == bus.rr2));
  assign bus.hazard = (bus.re1 && pend1) || (bus.re2 && pend2);

  assign bus.sb_err = sb_err_q;

  // next counter values: issue increments, writeback decrements, both cancel
  always_comb begin
    logic inc_i;
    logic dec_i;
    inc_i = 1'b0;
    dec_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt[i] = cnt[i];
      inc_i = iss_acc && (bus.iss_rd == ADDR_W'(i));
      dec_i = wr_ok && (bus.wr == ADDR_W'(i));
      if (inc_i && !dec_i) begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (dec_i && !inc_i && (cnt[i] != '0)) begin
        cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
    end
  end

  // counter state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_err_q <= 1'b0;
    end else if (underflow) begin
      sb_err_q <= 1'b1;
    end
  end

`else

  // plain register file: no tracking, no forwarding
  assign bus.rd1     = stored1;
  assign bus.rd2     = stored2;
  assign bus.hazard  = 1'b0;
  assign bus.iss_rdy = 1'b1;
  assign bus.sb_err  = 1'b0;

  // issue and read-use inputs have no function in this build
  logic             unused_sb_inputs;
  logic [CNT_W-1:0] unused_cnt;
  assign unused_sb_inputs = ^{bus.iss, bus.iss_rd, bus.re1, bus.re2};
  assign unused_cnt       = '0;

`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

`ifdef REGFILE_SB_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_sb #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .CNT_W(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_iss(input logic [4:0] a);
    @(negedge clk);
    bus.iss = 1'b1;
    bus.iss_rd = a;
    @(negedge clk);
    bus.iss = 1'b0;
  endtask

  task automatic test_reset;
    bus.rr1 = 5'd3; bus.rr2 = 5'd31; bus.dbg_addr = 5'd17;
    bus.re1 = 1'b1; bus.re2 = 1'b1; bus.iss_rd = 5'd3;
    @(negedge clk); #1;
    checks++; if (bus.rd1 !== 32'h0) begin errors++; $display("FAIL rst_rd1 got %h want 0", bus.rd1); end
    checks++; if (bus.rd2 !== 32'h0) begin errors++; $display("FAIL rst_rd2 got %h want 0", bus.rd2); end
    checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("FAIL rst_dbg got %h want 0", bus.dbg_data); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard got %b want 0", bus.hazard); end
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL rst_iss_rdy got %b want 1", bus.iss_rdy); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL rst_sb_err got %b want 0", bus.sb_err); end
    bus.re1 = 1'b0; bus.re2 = 1'b0;
  endtask

  task automatic test_write_read;
    do_iss(5'd8);
    do_iss(5'd31);
    @(negedge clk);
    bus.we = 1'b1; bus.wr = 5'd8; bus.wd = 32'hDEADBEEF;
    bus.rr1 = 5'd8; bus.rr2 = 5'd8; bus.re1 = 1'b1; bus.dbg_addr = 5'd8;
    #1;
    checks++; if (bus.rd1 !== (SB ? 32'hDEADBEEF : 32'h0)) begin errors++; $display("FAIL wr_same_cycle_rd1 got %h want %h", bus.rd1, SB ? 32'hDEADBEEF : 32'h0); end
    checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("FAIL wr_same_cycle_dbg got %h want 0", bus.dbg_data); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL wr_same_cycle_hazard got %b want 0", bus.hazard); end
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd1 got %h want deadbeef", bus.rd1); end
    checks++; if (bus.rd2 !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd2 got %h want deadbeef", bus.rd2); end
    checks++; if (bus.dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_dbg got %h want deadbeef", bus.dbg_data); end
    @(negedge clk);
    bus.we = 1'b1; bus.wr = 5'd0; bus.wd = 32'h1234; bus.rr1 = 5'd0; bus.dbg_addr = 5'd0;
    #1;
    checks++; if (bus.rd1 !== 32'h0) begin errors++; $display("FAIL zero_fwd_rd1 got %h want 0", bus.rd1); end
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.rd1 !== 32'h0) begin errors++; $display("FAIL zero_rd1 got %h want 0", bus.rd1); end
    checks++; if (bus.dbg_data !== 32'h0) begin errors++; $display("FAIL zero_dbg got %h want 0", bus.dbg_data); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL zero_sb_err got %b want 0", bus.sb_err); end
    @(negedge clk);
    bus.we = 1'b1; bus.wr = 5'd31; bus.wd = 32'hA5A5A5A5; bus.rr2 = 5'd31; bus.rr1 = 5'd8;
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.rd2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL top_reg_rd2 got %h want a5a5a5a5", bus.rd2); end
    checks++; if (bus.rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL keep_rd1 got %h want deadbeef", bus.rd1); end
    bus.re1 = 1'b0;
  endtask

  task automatic test_pending;
    do_iss(5'd9);
    @(negedge clk);
    bus.re1 = 1'b1; bus.rr1 = 5'd9; bus.iss_rd = 5'd9; #1;
    checks++; if (bus.hazard !== SB) begin errors++; $display("FAIL pend_hazard got %b want %b", bus.hazard, SB); end
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL pend_iss_rdy got %b want 1", bus.iss_rdy); end
    @(negedge clk);
    bus.we = 1'b1; bus.wr = 5'd9; bus.wd = 32'd5; #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL wb_hazard got %b want 0", bus.hazard); end
    checks++; if (bus.rd1 !== (SB ? 32'd5 : 32'd0)) begin errors++; $display("FAIL wb_fwd_rd1 got %h want %h", bus.rd1, SB ? 32'd5 : 32'd0); end
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL after_wb_hazard got %b want 0", bus.hazard); end
    checks++; if (bus.rd1 !== 32'd5) begin errors++; $display("FAIL after_wb_rd1 got %h want 5", bus.rd1); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL after_wb_sb_err got %b want 0", bus.sb_err); end
    bus.re1 = 1'b0;
  endtask

  task automatic test_overflow;
    @(negedge clk);
    bus.iss = 1'b1; bus.iss_rd = 5'd10; bus.re1 = 1'b1; bus.rr1 = 5'd10;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL ovf_rdy_%0d got %b want 1", k, bus.iss_rdy); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.iss_rdy !== !SB) begin errors++; $display("FAIL ovf_full_rdy got %b want %b", bus.iss_rdy, !SB); end
    checks++; if (bus.hazard !== SB) begin errors++; $display("FAIL ovf_full_hazard got %b want %b", bus.hazard, SB); end
    @(negedge clk);
    bus.iss = 1'b0; bus.we = 1'b1; bus.wr = 5'd10; bus.wd = 32'd1; #1;
    checks++; if (bus.hazard !== SB) begin errors++; $display("FAIL ovf_wb_hazard got %b want %b", bus.hazard, SB); end
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL ovf_after_rdy got %b want 1", bus.iss_rdy); end
    checks++; if (bus.hazard !== SB) begin errors++; $display("FAIL ovf_cnt2_hazard got %b want %b", bus.hazard, SB); end
    @(negedge clk);
    bus.we = 1'b1; bus.wd = 32'd2;
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.hazard !== SB) begin errors++; $display("FAIL ovf_cnt1_hazard got %b want %b", bus.hazard, SB); end
    @(negedge clk);
    bus.we = 1'b1; bus.wd = 32'd3; #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL ovf_last_wb_hazard got %b want 0", bus.hazard); end
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL ovf_drained_hazard got %b want 0", bus.hazard); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL ovf_sb_err got %b want 0", bus.sb_err); end
    checks++; if (bus.rd1 !== 32'd3) begin errors++; $display("FAIL ovf_rd1 got %h want 3", bus.rd1); end
    bus.re1 = 1'b0;
  endtask

  task automatic test_simul_iss_wb;
    do_iss(5'd11);
    @(negedge clk);
    bus.iss = 1'b1; bus.iss_rd = 5'd11; bus.we = 1'b1; bus.wr = 5'd11; bus.wd = 32'd77;
    bus.re1 = 1'b1; bus.rr1 = 5'd11; #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL simul_hazard got %b want 0", bus.hazard); end
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL simul_rdy got %b want 1", bus.iss_rdy); end
    @(negedge clk);
    bus.iss = 1'b0; bus.we = 1'b0; #1;
    checks++; if (bus.hazard !== SB) begin errors++; $display("FAIL simul_after_hazard got %b want %b", bus.hazard, SB); end
    checks++; if (bus.rd1 !== 32'd77) begin errors++; $display("FAIL simul_rd1 got %h want 77", bus.rd1); end
    @(negedge clk);
    bus.we = 1'b1; bus.wd = 32'd78;
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL simul_drain_hazard got %b want 0", bus.hazard); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL simul_sb_err got %b want 0", bus.sb_err); end
    bus.re1 = 1'b0;
  endtask

  task automatic test_underflow;
    @(negedge clk);
    bus.we = 1'b1; bus.wr = 5'd12; bus.wd = 32'hCAFE; bus.rr1 = 5'd12; #1;
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL unf_early_sb_err got %b want 0", bus.sb_err); end
    @(negedge clk);
    bus.we = 1'b0; #1;
    checks++; if (bus.rd1 !== 32'hCAFE) begin errors++; $display("FAIL unf_rd1 got %h want cafe", bus.rd1); end
    checks++; if (bus.sb_err !== SB) begin errors++; $display("FAIL unf_sb_err got %b want %b", bus.sb_err, SB); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.sb_err !== SB) begin errors++; $display("FAIL unf_sticky got %b want %b", bus.sb_err, SB); end
  endtask

  task automatic test_async_reset;
    do_iss(5'd9);
    do_iss(5'd9);
    @(negedge clk);
    bus.re1 = 1'b1; bus.rr1 = 5'd9; bus.iss_rd = 5'd9; bus.dbg_addr = 5'd8; #1;
    checks++; if (bus.rd1 !== 32'd5) begin errors++; $display("FAIL pre_rst_rd1 got %h want 5", bus.rd1); end
    checks++; if (bus.hazard !== SB) begin errors++; $display("FAIL pre_rst_hazard got %b want %b", bus.hazard, SB); end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (bus.rd1 !== 32'd0) begin errors++; $display("FAIL arst_rd1 got %h want 0", bus.rd1); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL arst_hazard got %b want 0", bus.hazard); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL arst_sb_err got %b want 0", bus.sb_err); end
    checks++; if (bus.iss_rdy !== 1'b1) begin errors++; $display("FAIL arst_iss_rdy got %b want 1", bus.iss_rdy); end
    checks++; if (bus.dbg_data !== 32'd0) begin errors++; $display("FAIL arst_dbg got %h want 0", bus.dbg_data); end
    bus.we = 1'b1; bus.wr = 5'd8; bus.wd = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.we = 1'b0;
    checks++; if (bus.dbg_data !== 32'd0) begin errors++; $display("FAIL in_rst_write got %h want 0", bus.dbg_data); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.dbg_data !== 32'd0) begin errors++; $display("FAIL post_rst_dbg got %h want 0", bus.dbg_data); end
    checks++; if (bus.hazard !== 1'b0) begin errors++; $display("FAIL post_rst_hazard got %b want 0", bus.hazard); end
    bus.re1 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.rr1 = '0; bus.rr2 = '0; bus.re1 = 1'b0; bus.re2 = 1'b0;
    bus.we = 1'b0; bus.wr = '0; bus.wd = '0;
    bus.iss = 1'b0; bus.iss_rd = '0; bus.dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_write_read();
    test_pending();
    test_overflow();
    test_simul_iss_wb();
    test_underflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
